systolic_feed_ctrl: RTL and testbench
=====================================

Name: systolic_feed_ctrl

Overview:
- Sequences one matrix-multiply pass on the dim_p x dim_p systolic array.
- Accepts one operand column vector per handshake from the upstream buffer (e.g. a SIPO-assembled word).
- Applies diagonal skew so lane r reaches array row r r cycles later than lane 0.
- Issues the accumulator clear, waits for the array to drain, then signals completion.

Parameters:
- dim_p, 4, array dimension (number of lanes/rows).
- width_p, 8, operand width per lane in bits.
- k_max_p, 16, maximum vectors per pass. Count width is $clog2(k_max_p+1).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  pass request; accepted only when ready_o=1.
- k_i  in  $clog2(k_max_p+1)  vectors in the pass; sampled on start accept. Values above k_max_p are undefined use.
- ready_o  out  1  controller idle, able to accept start_i.
- valid_i  in  1  upstream vector valid.
- data_i  in  dim_p*width_p  vector; lane r at bits [r*width_p +: width_p].
- yumi_o  out  1  vector consumed this cycle.
- row_valid_o  out  dim_p  per-lane valid into the array edge.
- row_data_o  out  dim_p*width_p  skewed lane data; a lane with row_valid_o[r]=0 drives zero.
- acc_clear_o  out  1  one-cycle accumulator clear.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset (synchronous, reset_i=1 at posedge), takes effect the next cycle:
  - state=IDLE, counters=0, all skew registers cleared.
  - ready_o=1, busy_o=0, yumi_o=0, acc_clear_o=0, done_o=0, row_valid_o=0, row_data_o=0.
  - A reset mid-pass aborts the pass with no done_o.
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - ready_o=1.
  - start_i=1 latches k_i and moves to CLEAR.
- CLEAR (exactly 1 cycle):
  - acc_clear_o=1.
  - Next state is STREAM if the latched k>0, else DONE.
- STREAM:
  - yumi_o = valid_i (combinational). A handshake increments in_cnt.
  - When the k-th vector is accepted, move to DRAIN; drain_cnt=0.
  - valid_i=0 produces no accept; a bubble (valid 0) enters the skew.
- DRAIN:
  - Runs exactly 2*dim_p-1 cycles, counted by drain_cnt, then moves to DONE.
  - yumi_o=0.
- DONE (1 cycle):
  - done_o=1, then IDLE.
- start_i outside IDLE is ignored; k_i is not resampled.
- yumi_o=0 in every state except STREAM.
- Skew timing:
  - For a vector accepted in cycle c, lane r presents data_i lane r with row_valid_o[r]=1 in cycle c+1+r.
  - Lane r is an (r+1)-deep register chain of {valid, data}; it shifts every cycle in all states and loads valid 0 when no accept occurs.
  - Bubbles keep their column alignment across lanes.
- Timing with no stalls, dim_p=4, k=3, start accepted cycle 0:
  - CLEAR in cycle 1.
  - Accepts in cycles 2, 3, 4.
  - DRAIN in cycles 5–11.
  - done_o in cycle 12; ready_o=1 from cycle 13.
- k=0: CLEAR, then DONE, then IDLE. done_o in cycle 2; no yumi_o.
- busy_o is the inverse of ready_o.

Decomposition:
- Package systolic_pkg holds:
  - the state enum typedef feed_state_e;
  - the function drain_cycles(dim) returning 2*dim-1.
- One sub-module, skew_delay: a parameterized depth-N shift register of {valid, width_p data}.
  - Instantiated per lane with depth r+1 from a generate loop.
  - Zero data when valid=0.

Test Plan:
- Reset then idle: hold reset_i 3 cycles, release -> ready_o=1, busy_o=0, and all outputs 0 for 5 idle cycles.
- Basic pass (dim_p=4, k=3, valid_i held 1, vectors {04,03,02,01}, {14,13,12,11}, {24,23,22,21}, start at cycle 0):
  - acc_clear_o=1 only in cycle 1; yumi_o in cycles 2–4.
  - Lane 0 carries 01/11/21 in cycles 3/4/5.
  - Lane 3 carries 04/14/24 in cycles 6/7/8.
  - done_o only in cycle 12.
- Backpressure (k=3, valid_i pattern 1,0,0,1,1 from cycle 2):
  - Accepts in cycles 2, 5, 6.
  - Lane r shows a two-cycle valid gap between the first and second vectors, aligned across lanes.
  - done_o in cycle 14.
- k=0: start with k_i=0 -> acc_clear_o in cycle 1, done_o in cycle 2, yumi_o never asserted, row_valid_o stays 0.
- Start while busy: pulse start_i with k_i=5 during STREAM -> ignored; pass completes with the original k=3 and exactly 3 yumi_o.
- Reset mid-pass: assert reset_i in the second STREAM cycle ->
  - the next cycle shows IDLE, ready_o=1, row_valid_o=0;
  - no done_o is ever emitted;
  - a fresh pass afterwards behaves as in the basic-pass scenario.

Source files
------------

// File: rtl/systolic_feed_ctrl_pkg.sv
// systolic_pkg: shared state type and timing helper for the systolic feed controller.
package systolic_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} feed_state_e;

    // The last column entering row dim-1 needs 2*dim-1 cycles to leave the array.
    function automatic int drain_cycles(int dim);
        return 2 * dim - 1;
    endfunction
endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// systolic_feed_ctrl_if: pass control, upstream vector handshake and array-edge feed.
interface systolic_feed_ctrl_if #(
    parameter int dim_p = 4,
    parameter int width_p = 8,
    parameter int k_max_p = 16
) ();
    logic start_i;
    logic [$clog2(k_max_p+1)-1:0] k_i;
    logic ready_o;
    logic valid_i;
    logic [dim_p*width_p-1:0] data_i;
    logic yumi_o;
    logic [dim_p-1:0] row_valid_o;
    logic [dim_p*width_p-1:0] row_data_o;
    logic acc_clear_o;
    logic busy_o;
    logic done_o;

    modport slave (
        input start_i, k_i, valid_i, data_i,
        output ready_o, yumi_o, row_valid_o, row_data_o, acc_clear_o, busy_o, done_o
    );
    modport master (
        output start_i, k_i, valid_i, data_i,
        input ready_o, yumi_o, row_valid_o, row_data_o, acc_clear_o, busy_o, done_o
    );
endinterface

// File: rtl/systolic_feed_ctrl_skew_delay.sv
// skew_delay: depth_p-stage shift register of {valid, data}; invalid slots carry zero data.
module skew_delay #(
    parameter int depth_p = 1,
    parameter int width_p = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic [width_p-1:0] data,
    output logic q_valid,
    output logic [width_p-1:0] q_data
);
    logic [depth_p-1:0] v;
    logic [width_p-1:0] d [depth_p];

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < depth_p; i++) d[i] <= '0;
        end else begin
            v[0] <= valid;
            d[0] <= valid ? data : '0;
            for (int i = 1; i < depth_p; i++) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
            end
        end
    end

    assign q_valid = v[depth_p-1];
    assign q_data = d[depth_p-1];
endmodule

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: sequences one pass (clear, stream k vectors, drain, done)
// and diagonally skews each accepted vector onto the array rows.
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int dim_p = 4,
    parameter int width_p = 8,
    parameter int k_max_p = 16
) (
    input logic clk_i,
    input logic reset_i,
    systolic_feed_ctrl_if.slave bus
);
    localparam int cnt_w = $clog2(k_max_p + 1);
    localparam int drain_n = drain_cycles(dim_p);
    localparam int drain_w = $clog2(drain_n + 1);

    feed_state_e state;
    logic [cnt_w-1:0] k_q;
    logic [cnt_w-1:0] in_cnt;
    logic [drain_w-1:0] drain_cnt;
    logic ready;
    logic acc_clear;
    logic done;
    logic [dim_p-1:0] row_valid;
    logic [dim_p*width_p-1:0] row_data;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            k_q <= '0;
            in_cnt <= '0;
            drain_cnt <= '0;
            ready <= 1'b1;
            acc_clear <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start_i) begin
                    k_q <= bus.k_i;
                    in_cnt <= '0;
                    ready <= 1'b0;
                    acc_clear <= 1'b1;
                    state <= CLEAR;
                end
                CLEAR: begin
                    acc_clear <= 1'b0;
                    done <= k_q == '0;
                    state <= (k_q == '0) ? DONE : STREAM;
                end
                STREAM: if (bus.valid_i) begin
                    in_cnt <= in_cnt + cnt_w'(1);
                    if (in_cnt + cnt_w'(1) == k_q) begin
                        drain_cnt <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + drain_w'(1);
                    if (drain_cnt == drain_w'(drain_n - 1)) begin
                        done <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane r is delayed r+1 cycles so each column enters the array as a diagonal.
    for (genvar r = 0; r < dim_p; r++) begin : g_lane
        skew_delay #(.depth_p(r + 1), .width_p(width_p)) u_skew (
            .clk(clk_i),
            .rst(reset_i),
            .valid(bus.yumi_o),
            .data(bus.data_i[r*width_p +: width_p]),
            .q_valid(row_valid[r]),
            .q_data(row_data[r*width_p +: width_p])
        );
    end

    assign bus.yumi_o = (state == STREAM) && bus.valid_i;
    assign bus.ready_o = ready;
    assign bus.busy_o = ~ready;
    assign bus.acc_clear_o = acc_clear;
    assign bus.done_o = done;
    assign bus.row_valid_o = row_valid;
    assign bus.row_data_o = row_data;
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: per-cycle control table plus lane scoreboard for the feed controller.
module tb_systolic_feed_ctrl;
    localparam int D = 4;
    localparam int W = 8;

    typedef struct {
        bit st;
        int k;
        bit v;
        logic [D*W-1:0] d;
        bit r;
        bit y;
        bit c;
        bit dn;
    } rec_t;

    typedef struct {
        logic [W-1:0] d;
        int due;
    } sb_t;

    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    systolic_feed_ctrl_if #(.dim_p(D), .width_p(W), .k_max_p(16)) bus ();
    systolic_feed_ctrl #(.dim_p(D), .width_p(W), .k_max_p(16)) dut (
        .clk_i(clk),
        .reset_i(reset),
        .bus(bus)
    );

    sb_t sbq [D][$];
    rec_t tab[$];
    rec_t cur;
    bit chk = 0;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    localparam logic [D*W-1:0] V0 = 32'h04030201;
    localparam logic [D*W-1:0] V1 = 32'h14131211;
    localparam logic [D*W-1:0] V2 = 32'h24232221;
    localparam logic [D*W-1:0] J = 32'hdeadbeef;

    function automatic rec_t mk(bit st, int k, bit v, logic [D*W-1:0] d, bit r, bit y, bit c, bit dn);
        rec_t t;
        t.st = st; t.k = k; t.v = v; t.d = d;
        t.r = r; t.y = y; t.c = c; t.dn = dn;
        return t;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(rec_t t);
        logic [31:0] kk;
        kk = t.k;
        cur = t;
        bus.start_i = t.st;
        bus.k_i = kk[4:0];
        bus.valid_i = t.v;
        bus.data_i = t.d;
    endtask

    task automatic run_tab();
        foreach (tab[i]) begin
            drive(tab[i]);
            tick();
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            drive(mk(0, 0, 0, '0, 1, 0, 0, 0));
            tick();
        end
    endtask

    task automatic fill_basic(bit busy_start);
        tab.delete();
        tab.push_back(mk(1, 3, 0, '0, 1, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, V0, 0, 0, 1, 0));
        tab.push_back(mk(0, 0, 1, V0, 0, 1, 0, 0));
        tab.push_back(mk(busy_start, 5, 1, V1, 0, 1, 0, 0));
        tab.push_back(mk(0, 0, 1, V2, 0, 1, 0, 0));
        for (int c = 5; c <= 11; c++) tab.push_back(mk(0, 0, 1, J, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, '0, 0, 0, 0, 1));
        tab.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0));
    endtask

    task automatic fill_bp();
        tab.delete();
        tab.push_back(mk(1, 3, 0, '0, 1, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, J, 0, 0, 1, 0));
        tab.push_back(mk(0, 0, 1, V0, 0, 1, 0, 0));
        tab.push_back(mk(0, 0, 0, J, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, J, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, V1, 0, 1, 0, 0));
        tab.push_back(mk(0, 0, 1, V2, 0, 1, 0, 0));
        for (int c = 7; c <= 13; c++) tab.push_back(mk(0, 0, 0, '0, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, '0, 0, 0, 0, 1));
        tab.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0));
    endtask

    task automatic fill_k0();
        tab.delete();
        tab.push_back(mk(1, 0, 0, '0, 1, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, J, 0, 0, 1, 0));
        tab.push_back(mk(0, 0, 1, J, 0, 0, 0, 1));
        tab.push_back(mk(0, 0, 1, J, 1, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0));
    endtask

    // Every cycle: compare control outputs, enqueue accepted lanes, match lane outputs.
    always @(negedge clk) begin
        sb_t e;
        if (chk) begin
            check("ctrl{rdy,busy,yumi,clr,done}",
                  {bus.ready_o, bus.busy_o, bus.yumi_o, bus.acc_clear_o, bus.done_o},
                  {cur.r, !cur.r, cur.y, cur.c, cur.dn});
            if (cur.y)
                for (int r = 0; r < D; r++) sbq[r].push_back('{cur.d[r*W +: W], cyc + 1 + r});
            for (int r = 0; r < D; r++) begin
                if (sbq[r].size() > 0 && sbq[r][0].due == cyc) begin
                    e = sbq[r].pop_front();
                    check($sformatf("lane%0d_valid", r), bus.row_valid_o[r], 1);
                    check($sformatf("lane%0d_data", r), bus.row_data_o[r*W +: W], e.d);
                end else begin
                    check($sformatf("lane%0d_idle", r), {bus.row_valid_o[r], bus.row_data_o[r*W +: W]}, 0);
                end
            end
        end
    end

    initial begin
        drive(mk(0, 0, 0, '0, 1, 0, 0, 0));
        reset = 1;
        repeat (3) tick();
        reset = 0;
        chk = 1;
        idle(5);

        fill_basic(0);
        run_tab();
        fill_bp();
        run_tab();
        fill_k0();
        run_tab();
        fill_basic(1);
        run_tab();

        fill_basic(0);
        for (int i = 0; i < 3; i++) begin
            drive(tab[i]);
            tick();
        end
        drive(tab[3]);
        reset = 1;
        tick();
        reset = 0;
        for (int r = 0; r < D; r++) sbq[r].delete();
        idle(15);
        fill_basic(0);
        run_tab();

        chk = 0;
        for (int r = 0; r < D; r++) check($sformatf("sb%0d_empty", r), sbq[r].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
